alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the execute-stage ALU. Accepts one decoded instruction per transfer on a valid/ready input channel, returns a registered result on a valid/ready output channel, and adds an iterative multi-cycle multiplier, signed compare and explicit branch-taken/illegal-op flags. Sits between decode/register-read and memory/writeback, driving the data-memory address and the PC redirect.

## Interface
- XLEN, 32, datapath width (≥8, power of two)
- ADDR_W, 12, memory/branch address width (≤ XLEN)
- SHW, $clog2(XLEN), shift-amount width (derived, not overridable)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept this cycle
- in_op  in  7  opcode
- in_funct3  in  3  sub-operation
- in_funct7  in  7  carried, reserved (must not affect result)
- in_data_a  in  XLEN  rs1 value
- in_data_b  in  XLEN  rs2 value
- in_imm  in  XLEN  sign-extended immediate
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_result  out  XLEN  arithmetic result
- out_addr  out  ADDR_W  load/store address or branch target
- out_read2  out  1  store: rs2 is write data
- out_taken  out  1  branch condition true
- out_err  out  1  illegal opcode/funct3

## Operation
- Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011; any other opcode → out_err=1.
- R funct3: 0 a+b, 1 a−b, 2 a|b, 3 a&b, 4 a^b, 5 ~a, 6 MUL (low XLEN bits of a·b, unsigned), 7 SLT (signed a<b → 1 else 0).
- I funct3: 0 a+imm, 1 a−imm, 2 a|imm, 3 a&imm, 4 a<<imm[SHW-1:0], 5 a>>imm[SHW-1:0] logical; 6,7 → out_err.
- LOAD funct3=1, STORE funct3=0: out_addr = (a+imm)[ADDR_W-1:0]; out_read2=1 for STORE only; other funct3 → out_err.
- BRANCH funct3: 0 BEQ a==b, 4 BLT signed a<b, 5 BGT signed a>b, 6 BEZ a==0; out_addr = imm[ADDR_W-1:0] always, out_taken = condition; other funct3 → out_err.
- On out_err: out_result=0, out_taken=0, out_read2=0, out_addr=0. Never drive X/Z.
- Fields not written by an op are 0 in that result (no stale values).
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
- FSM: IDLE → (accept MUL) → MUL (shift-add, one multiplier bit per cycle, XLEN cycles) → DONE; IDLE → (accept other) → DONE; DONE → (out_ready) → IDLE, or DONE → DONE when a new non-MUL is accepted the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Never high in MUL.

## Timing
- Reset: state IDLE, out_valid=0, all outputs 0, multiplier counter/accumulator 0; async assert, release synchronous to clk.
- Non-MUL latency 1: accepted in cycle N → out_valid in N+1.
- MUL latency XLEN+1: accepted in N → out_valid in N+XLEN+1.
- Throughput one non-MUL per cycle when out_ready held high.
- Output payload stable while out_valid & !out_ready.
- Transfer on valid&ready only; inputs ignored otherwise.
- Simultaneous output pop and MUL accept: DONE → MUL, out_valid drops next cycle.
- Reset mid-MUL: operation discarded, no output produced.

## Structure
- Package alu_pkg: opcode localparams, funct3 enums for R/I/BRANCH, FSM state typedef.
- Sub-module alu_mul_iter: XLEN-parametrised shift-add multiplier with start/busy/done; the rest stays in alu_pipe.

## Test plan
- Reset mid-traffic (rst_n low with out_valid=1) → all outputs 0, in_ready=1 next edge after release.
- R ADD a=0xFFFF_FFFF, b=1, out_ready=1 → out_result=0 one cycle later; back-to-back SUB 5−7 → 0xFFFF_FFFE next cycle.
- MUL a=0x0001_0003, b=0x0000_0005 → out_result=0x0005_000F exactly 33 cycles after accept; in_ready=0 throughout MUL.
- Backpressure: out_ready=0 for 4 cycles after I ORI a=0xF0, imm=0x0F → out_result=0xFF held stable, in_ready=0, then one transfer.
- BLT a=0xFFFF_FFFF (−1), b=1, imm=0x123 → out_taken=1, out_addr=0x123; BGT same operands → out_taken=0.
- STORE a=0x100, imm=0x20 → out_addr=0x120, out_read2=1; opcode 0x7F → out_err=1, other outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, funct3 encodings and FSM state type for alu_pipe
package alu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LOAD  = 3'd1;
    localparam logic [2:0] F3_STORE = 3'd0;

    typedef enum logic [2:0] {
        R_ADD = 3'd0, R_SUB = 3'd1, R_OR  = 3'd2, R_AND = 3'd3,
        R_XOR = 3'd4, R_NOT = 3'd5, R_MUL = 3'd6, R_SLT = 3'd7
    } r_funct_e;

    typedef enum logic [2:0] {
        I_ADD = 3'd0, I_SUB = 3'd1, I_OR  = 3'd2,
        I_AND = 3'd3, I_SLL = 3'd4, I_SRL = 3'd5
    } i_funct_e;

    typedef enum logic [2:0] {
        BR_EQ = 3'd0, BR_LT = 3'd4, BR_GT = 3'd5, BR_EZ = 3'd6
    } br_funct_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - instruction-in / result-out handshake bundle for alu_pipe
// master: decode side (drives in_*, out_ready); slave: the ALU (drives in_ready, out_*)
interface alu_pipe_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_op;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [XLEN-1:0]   in_data_a;
    logic [XLEN-1:0]   in_data_b;
    logic [XLEN-1:0]   in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_result;
    logic [ADDR_W-1:0] out_addr;
    logic              out_read2;
    logic              out_taken;
    logic              out_err;

    modport master (
        output in_valid, in_op, in_funct3, in_funct7, in_data_a, in_data_b, in_imm, out_ready,
        input  in_ready, out_valid, out_result, out_addr, out_read2, out_taken, out_err
    );

    modport slave (
        input  in_valid, in_op, in_funct3, in_funct7, in_data_a, in_data_b, in_imm, out_ready,
        output in_ready, out_valid, out_result, out_addr, out_read2, out_taken, out_err
    );
endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - shift-add multiplier, one multiplier bit per cycle, XLEN cycles
// ports: clk, rst_n, start (load a/b), a, b, busy (iterating), done (final step this cycle),
//        product (valid in the cycle done is high: low XLEN bits of a*b, unsigned)
module alu_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [SHW-1:0]  cnt;

    // product is the accumulator after the current step, so the final sum is
    // available combinationally on the last iteration cycle without an extra edge
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (cnt == SHW'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked execute-stage ALU with iterative multiplier
// ports: clk, rst_n (async, active-low), bus (alu_pipe_if.slave: instruction in, result out)
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    state_e            state_q, state_d;
    logic              accept, is_mul;
    logic              mul_busy, mul_done;
    logic [XLEN-1:0]   mul_product;
    logic [XLEN-1:0]   eff_addr;
    logic [XLEN-1:0]   c_result;
    logic [ADDR_W-1:0] c_addr;
    logic              c_read2, c_taken, c_err;
    logic [XLEN-1:0]   r_result;
    logic [ADDR_W-1:0] r_addr;
    logic              r_read2, r_taken, r_err;
    logic              unused_funct7;

    // funct7 travels with the instruction but never selects an operation
    assign unused_funct7 = ^bus.in_funct7;

    assign bus.in_ready = ((state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready)) && !mul_busy;
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_mul       = (bus.in_op == OP_R) && (bus.in_funct3 == R_MUL);
    assign eff_addr     = bus.in_data_a + bus.in_imm;

    alu_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (bus.in_data_a),
        .b       (bus.in_data_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        c_result = '0;
        c_addr   = '0;
        c_read2  = 1'b0;
        c_taken  = 1'b0;
        c_err    = 1'b0;
        case (bus.in_op)
            OP_R: begin
                case (bus.in_funct3)
                    R_ADD: c_result = bus.in_data_a + bus.in_data_b;
                    R_SUB: c_result = bus.in_data_a - bus.in_data_b;
                    R_OR:  c_result = bus.in_data_a | bus.in_data_b;
                    R_AND: c_result = bus.in_data_a & bus.in_data_b;
                    R_XOR: c_result = bus.in_data_a ^ bus.in_data_b;
                    R_NOT: c_result = ~bus.in_data_a;
                    R_MUL: c_result = '0;
                    R_SLT: c_result = {{(XLEN-1){1'b0}}, ($signed(bus.in_data_a) < $signed(bus.in_data_b))};
                endcase
            end
            OP_I: begin
                case (bus.in_funct3)
                    I_ADD:   c_result = bus.in_data_a + bus.in_imm;
                    I_SUB:   c_result = bus.in_data_a - bus.in_imm;
                    I_OR:    c_result = bus.in_data_a | bus.in_imm;
                    I_AND:   c_result = bus.in_data_a & bus.in_imm;
                    I_SLL:   c_result = bus.in_data_a << bus.in_imm[SHW-1:0];
                    I_SRL:   c_result = bus.in_data_a >> bus.in_imm[SHW-1:0];
                    default: c_err    = 1'b1;
                endcase
            end
            OP_LOAD: begin
                if (bus.in_funct3 == F3_LOAD) c_addr = eff_addr[ADDR_W-1:0];
                else                          c_err  = 1'b1;
            end
            OP_STORE: begin
                if (bus.in_funct3 == F3_STORE) begin
                    c_addr  = eff_addr[ADDR_W-1:0];
                    c_read2 = 1'b1;
                end else begin
                    c_err = 1'b1;
                end
            end
            OP_BRANCH: begin
                case (bus.in_funct3)
                    BR_EQ: c_taken = (bus.in_data_a == bus.in_data_b);
                    BR_LT: c_taken = ($signed(bus.in_data_a) < $signed(bus.in_data_b));
                    BR_GT: c_taken = ($signed(bus.in_data_a) > $signed(bus.in_data_b));
                    BR_EZ: c_taken = (bus.in_data_a == '0);
                    default: c_err = 1'b1;
                endcase
                // target only reported for legal branches so an error result stays all-zero
                if (!c_err) c_addr = bus.in_imm[ADDR_W-1:0];
            end
            default: c_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_mul ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_done) state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = accept ? (is_mul ? ST_MUL : ST_DONE) : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            r_result <= '0;
            r_addr   <= '0;
            r_read2  <= 1'b0;
            r_taken  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && !is_mul) begin
                r_result <= c_result;
                r_addr   <= c_addr;
                r_read2  <= c_read2;
                r_taken  <= c_taken;
                r_err    <= c_err;
            end else if (mul_done) begin
                r_result <= mul_product;
                r_addr   <= '0;
                r_read2  <= 1'b0;
                r_taken  <= 1'b0;
                r_err    <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_result = r_result;
    assign bus.out_addr   = r_addr;
    assign bus.out_read2  = r_read2;
    assign bus.out_taken  = r_taken;
    assign bus.out_err    = r_err;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe with reference model and random traffic
module tb_alu_pipe;
    localparam int XLEN    = 32;
    localparam int ADDR_W  = 12;
    localparam int MUL_LAT = XLEN + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    alu_pipe #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] res;
        logic [11:0] addr;
        bit          rd2;
        bit          tk;
        bit          err;
        int          acc;
        int          rdy;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    bit   rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        exp_t e;
        logic [31:0] ea;
        e.res = 0; e.addr = 0; e.rd2 = 0; e.tk = 0; e.err = 0; e.acc = 0; e.rdy = 0;
        ea = a + imm;
        case (op)
            7'h33: case (f3)
                3'd0: e.res = a + b;
                3'd1: e.res = a - b;
                3'd2: e.res = a | b;
                3'd3: e.res = a & b;
                3'd4: e.res = a ^ b;
                3'd5: e.res = ~a;
                3'd6: e.res = a * b;
                default: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            endcase
            7'h13: case (f3)
                3'd0: e.res = a + imm;
                3'd1: e.res = a - imm;
                3'd2: e.res = a | imm;
                3'd3: e.res = a & imm;
                3'd4: e.res = a << imm[4:0];
                3'd5: e.res = a >> imm[4:0];
                default: e.err = 1;
            endcase
            7'h03: if (f3 == 3'd1) e.addr = ea[11:0]; else e.err = 1;
            7'h23: if (f3 == 3'd0) begin e.addr = ea[11:0]; e.rd2 = 1; end else e.err = 1;
            7'h63: case (f3)
                3'd0: begin e.addr = imm[11:0]; e.tk = (a == b); end
                3'd4: begin e.addr = imm[11:0]; e.tk = ($signed(a) < $signed(b)); end
                3'd5: begin e.addr = imm[11:0]; e.tk = ($signed(a) > $signed(b)); end
                3'd6: begin e.addr = imm[11:0]; e.tk = (a == 0); end
                default: e.err = 1;
            endcase
            default: e.err = 1;
        endcase
        return e;
    endfunction

    // monitor: protocol expectations and payload checks from the scoreboard head
    always @(negedge clk) begin
        if (mon_en) begin
            bit   pend, ev, eir;
            exp_t h;
            pend = (sb.size() > 0) && (sb[0].acc < cyc);
            ev   = pend && (cyc >= sb[0].rdy);
            eir  = ev ? bus.out_ready : !pend;
            if (bus.out_valid !== ev) begin
                $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, bus.out_valid, ev);
                miscompares++;
            end
            if (bus.in_ready !== eir) begin
                $display("FAIL in_ready cyc=%0d: got %b expected %b", cyc, bus.in_ready, eir);
                miscompares++;
            end
            if (ev && bus.out_valid) begin
                h = sb[0];
                if ({bus.out_result, bus.out_addr, bus.out_read2, bus.out_taken, bus.out_err}
                    !== {h.res, h.addr, h.rd2, h.tk, h.err}) begin
                    $display("FAIL payload cyc=%0d: got res=%h addr=%h rd2=%b tk=%b err=%b expected res=%h addr=%h rd2=%b tk=%b err=%b",
                             cyc, bus.out_result, bus.out_addr, bus.out_read2, bus.out_taken, bus.out_err,
                             h.res, h.addr, h.rd2, h.tk, h.err);
                    miscompares++;
                end
                if (bus.out_ready) begin
                    void'(sb.pop_front());
                    vectors++;
                end
            end
        end
    end

    task automatic scramble_idle_inputs();
        bus.in_op     = 7'($urandom);
        bus.in_funct3 = 3'($urandom);
        bus.in_funct7 = 7'($urandom);
        bus.in_data_a = $urandom;
        bus.in_data_b = $urandom;
        bus.in_imm    = $urandom;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        exp_t e;
        bit   done;
        int   waited;
        e = model(op, f3, a, b, imm);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_funct3 = f3;
        bus.in_funct7 = 7'($urandom);
        bus.in_data_a = a;
        bus.in_data_b = b;
        bus.in_imm    = imm;
        done = 0;
        waited = 0;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.acc = cyc;
                e.rdy = cyc + ((op == 7'h33 && f3 == 3'd6) ? MUL_LAT : 1);
                sb.push_back(e);
                done = 1;
            end else begin
                waited++;
                if (waited > 200) begin
                    $display("FAIL accept_timeout: in_ready=%b expected 1 within 200 cycles", bus.in_ready);
                    miscompares++;
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        scramble_idle_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() > 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (sb.size() > 0) begin
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            miscompares++;
        end
    endtask

    task automatic do_reset(input int n);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        sb.delete();
        vectors++;
        if ({bus.out_valid, bus.out_result, bus.out_addr, bus.out_read2, bus.out_taken, bus.out_err} !== '0) begin
            $display("FAIL reset_outputs: got v=%b res=%h addr=%h rd2=%b tk=%b err=%b expected all 0",
                     bus.out_valid, bus.out_result, bus.out_addr, bus.out_read2, bus.out_taken, bus.out_err);
            miscompares++;
        end
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            $display("FAIL post_reset: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
            miscompares++;
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_data();
        logic [31:0] corners [4];
        corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        logic [6:0]  op;
        logic [31:0] a, b;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        scramble_idle_inputs();
        @(posedge clk);
        #1;
        do_reset(3);

        send(7'h33, 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        send(7'h33, 3'd1, 32'h5, 32'h7, 32'h0);
        send(7'h33, 3'd6, 32'h0001_0003, 32'h5, 32'h0);
        wait_drain();

        bus.out_ready = 1'b0;
        send(7'h13, 3'd2, 32'hF0, 32'h0, 32'h0F);
        idle(3);
        bus.out_ready = 1'b1;

        send(7'h63, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h123);
        send(7'h63, 3'd5, 32'hFFFF_FFFF, 32'h1, 32'h123);
        send(7'h63, 3'd0, 32'h55, 32'h55, 32'hABC);
        send(7'h63, 3'd6, 32'h0, 32'h9, 32'h456);
        send(7'h63, 3'd2, 32'h0, 32'h0, 32'h456);
        send(7'h23, 3'd0, 32'h100, 32'hDEAD_BEEF, 32'h20);
        send(7'h03, 3'd1, 32'hFFF, 32'h0, 32'h2);
        send(7'h03, 3'd0, 32'h100, 32'h0, 32'h20);
        send(7'h7F, 3'd0, 32'h1234, 32'h5678, 32'h9);
        send(7'h13, 3'd4, 32'h1, 32'h0, 32'hFFFF_FFFF);
        send(7'h13, 3'd5, 32'h8000_0000, 32'h0, 32'h1F);
        send(7'h13, 3'd6, 32'h1, 32'h1, 32'h1);
        send(7'h33, 3'd7, 32'h8000_0000, 32'h1, 32'h0);
        send(7'h33, 3'd0, 32'h3, 32'h4, 32'h0);
        send(7'h33, 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        wait_drain();

        bus.out_ready = 1'b0;
        send(7'h33, 3'd0, 32'h11, 32'h22, 32'h0);
        idle(2);
        do_reset(2);
        bus.out_ready = 1'b1;

        send(7'h33, 3'd6, 32'h1234_5678, 32'h9, 32'h0);
        idle(5);
        do_reset(2);
        idle(40);

        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: op = 7'h33;
                3, 4:    op = 7'h13;
                5:       op = 7'h03;
                6:       op = 7'h23;
                7, 8:    op = 7'h63;
                default: op = 7'($urandom);
            endcase
            a = pick_data();
            b = pick_data();
            if ($urandom_range(0, 3) == 0) b = a;
            send(op, 3'($urandom), a, b, pick_data());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        wait_drain();
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
